// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, source muxing, ALU and branch/jump resolution.
// Results are captured into the EX/MEM register. The redirect outputs go combinationally to fetch.
module ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic            BranchE,
    input  logic            ALUSrcAE,
    input  logic [1:0]      ALUSrcBE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [REGW-1:0] RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [2:0]      funct3M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [REGW-1:0] RdM
);

    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_e;

    logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b;
    logic [XLEN-1:0] alu_result_d, jalr_sum;
    logic [SHW-1:0]  shamt;
    logic            br_cond;

    logic            reg_write_q, mem_write_q;
    logic [1:0]      result_src_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] alu_result_q, write_data_q, pc_plus4_q;
    logic [REGW-1:0] rd_q;

    // Forward-from-M uses this stage's own registered result.
    always_comb begin
        fwd_a = RD1E;
        fwd_b = RD2E;
        case (ForwardAE)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = alu_result_q;
            default: fwd_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = alu_result_q;
            default: fwd_b = RD2E;
        endcase
    end

    always_comb begin
        src_a = ALUSrcAE ? PCE : fwd_a;
        src_b = fwd_b;
        case (ALUSrcBE)
            2'b01:   src_b = ImmExtE;
            2'b10:   src_b = XLEN'(4);
            2'b11:   src_b = '0;
            default: src_b = fwd_b;
        endcase
    end

    always_comb begin
        alu_result_d = '0;
        shamt        = src_b[SHW-1:0];
        case (alu_op_e'(ALUControlE))
            ALU_ADD:  alu_result_d = src_a + src_b;
            ALU_SUB:  alu_result_d = src_a - src_b;
            ALU_AND:  alu_result_d = src_a & src_b;
            ALU_OR:   alu_result_d = src_a | src_b;
            ALU_XOR:  alu_result_d = src_a ^ src_b;
            ALU_SLT:  alu_result_d = XLEN'($signed(src_a) < $signed(src_b));
            ALU_SLTU: alu_result_d = XLEN'(src_a < src_b);
            ALU_SLL:  alu_result_d = src_a << shamt;
            ALU_SRL:  alu_result_d = src_a >> shamt;
            ALU_SRA:  alu_result_d = XLEN'($signed(src_a) >>> shamt);
            ALU_PASS: alu_result_d = src_b;
            default:  alu_result_d = '0;
        endcase
    end

    // Branch condition compares forwarded register operands, never the ALU sources.
    always_comb begin
        br_cond = 1'b0;
        case (funct3E)
            3'b000:  br_cond = (fwd_a == fwd_b);
            3'b001:  br_cond = (fwd_a != fwd_b);
            3'b100:  br_cond = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_cond = (fwd_a < fwd_b);
            3'b111:  br_cond = (fwd_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    assign jalr_sum  = fwd_a + ImmExtE;
    assign PCSrcE    = JumpE | (BranchE & br_cond);
    assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            funct3_q     <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= RegWriteE;
            mem_write_q  <= MemWriteE;
            result_src_q <= ResultSrcE;
            funct3_q     <= funct3E;
            alu_result_q <= alu_result_d;
            write_data_q <= fwd_b;
            pc_plus4_q   <= PCPlus4E;
            rd_q         <= RdE;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign funct3M    = funct3_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, hand sequences for forwarding,
// bubbles and async reset, then random stimulus against an arithmetic reference model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcAE;
    logic [1:0]  ALUSrcBE, ResultSrcE, ForwardAE, ForwardBE;
    logic [3:0]  ALUControlE;
    logic [2:0]  funct3E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW;
    logic [4:0]  RdE;
    logic        PCSrcE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RdM;

    ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE),
        .BranchE(BranchE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .funct3M(funct3M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        asel;
        logic [1:0]  bsel, fa, fb, rsrc;
        logic [31:0] rd1, rd2, pc, pc4, imm, resw;
        logic        br, jmp, jalr, rw, mw;
        logic [2:0]  f3;
        logic [4:0]  rdx;
        logic [31:0] exp_alu;
        logic        exp_pcsrc;
        logic [31:0] exp_tgt;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [31:0] exp_m    = 32'h0;   // model of the value held in ALUResultM
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rd,
                                          input logic [31:0] resw, input logic [31:0] mval);
        if (sel == 2'b01) return resw;
        if (sel == 2'b10) return mval;
        return rd;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        case (op)
            4'd0:  return 32'(longint'(a) + longint'(b));
            4'd1:  return 32'(longint'(a) - longint'(b));
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd7:  return 32'(longint'(a) * (64'd1 << sh));
            4'd8:  return 32'(longint'(a) / (64'd1 << sh));
            4'd9:  return 32'(sa >>> sh);
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return longint'(a) < longint'(b);
            3'd7: return longint'(a) >= longint'(b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t model(input vec_t v, input logic [31:0] mval);
        vec_t r;
        logic [31:0] a, b, sa, sb;
        r  = v;
        a  = m_fwd(v.fa, v.rd1, v.resw, mval);
        b  = m_fwd(v.fb, v.rd2, v.resw, mval);
        sa = v.asel ? v.pc : a;
        case (v.bsel)
            2'b00: sb = b;
            2'b01: sb = v.imm;
            2'b10: sb = 32'd4;
            default: sb = 32'd0;
        endcase
        r.exp_alu   = m_alu(v.op, sa, sb);
        r.exp_pcsrc = v.jmp || (v.br && m_cond(v.f3, a, b));
        r.exp_tgt   = v.jalr ? ((a + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
        return r;
    endfunction

    function automatic vec_t blank();
        vec_t v;
        v = '{op: 4'd0, asel: 1'b0, bsel: 2'd0, fa: 2'd0, fb: 2'd0, rsrc: 2'd0,
              rd1: 32'd0, rd2: 32'd0, pc: 32'd0, pc4: 32'd0, imm: 32'd0, resw: 32'd0,
              br: 1'b0, jmp: 1'b0, jalr: 1'b0, rw: 1'b0, mw: 1'b0, f3: 3'd0, rdx: 5'd0,
              exp_alu: 32'd0, exp_pcsrc: 1'b0, exp_tgt: 32'd0};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ALUControlE = v.op;   ALUSrcAE = v.asel;  ALUSrcBE = v.bsel;
        ForwardAE   = v.fa;   ForwardBE = v.fb;   ResultSrcE = v.rsrc;
        RD1E = v.rd1; RD2E = v.rd2; PCE = v.pc; PCPlus4E = v.pc4; ImmExtE = v.imm;
        ResultW = v.resw; BranchE = v.br; JumpE = v.jmp; JalrE = v.jalr;
        RegWriteE = v.rw; MemWriteE = v.mw; funct3E = v.f3; RdE = v.rdx;
    endtask

    // Drive on the falling edge, check redirect before the rising edge, EX/MEM after it.
    task automatic run_vec(input string tag, input vec_t v);
        logic [31:0] exp_wd;
        @(negedge clk);
        drive(v);
        exp_wd = m_fwd(v.fb, v.rd2, v.resw, exp_m);
        #1;
        chk({tag, ".PCSrcE"}, 32'(PCSrcE), 32'(v.exp_pcsrc));
        chk({tag, ".PCTargetE"}, PCTargetE, v.exp_tgt);
        @(posedge clk);
        #1;
        chk({tag, ".ALUResultM"}, ALUResultM, v.exp_alu);
        chk({tag, ".WriteDataM"}, WriteDataM, exp_wd);
        chk({tag, ".ctrlM"}, {22'd0, RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM},
            {22'd0, v.rw, v.mw, v.rsrc, v.f3, v.rdx});
        chk({tag, ".PCPlus4M"}, PCPlus4M, v.pc4);
        exp_m = v.exp_alu;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".RegWriteM"}, 32'(RegWriteM), 32'd0);
        chk({tag, ".MemWriteM"}, 32'(MemWriteM), 32'd0);
        chk({tag, ".ResultSrcM"}, 32'(ResultSrcM), 32'd0);
        chk({tag, ".funct3M"}, 32'(funct3M), 32'd0);
        chk({tag, ".ALUResultM"}, ALUResultM, 32'd0);
        chk({tag, ".WriteDataM"}, WriteDataM, 32'd0);
        chk({tag, ".PCPlus4M"}, PCPlus4M, 32'd0);
        chk({tag, ".RdM"}, 32'(RdM), 32'd0);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v = blank();
        v.op = 4'($urandom_range(0, 15)); v.asel = 1'($urandom); v.bsel = 2'($urandom);
        v.fa = 2'($urandom); v.fb = 2'($urandom); v.rsrc = 2'($urandom);
        v.rd1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        v.rd2 = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
        v.pc = $urandom & 32'hFFFF_FFFC; v.pc4 = v.pc + 32'd4; v.imm = $urandom;
        v.resw = $urandom; v.br = 1'($urandom); v.jmp = 1'($urandom); v.jalr = 1'($urandom);
        v.rw = 1'($urandom); v.mw = 1'($urandom); v.f3 = 3'($urandom); v.rdx = 5'($urandom);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // Directed table: {inputs, expected ALUResultM, PCSrcE, PCTargetE}
        v = blank(); v.op = 4'd0; v.rd1 = 32'd5; v.rd2 = 32'd7; v.rw = 1'b1; v.rdx = 5'd3;
        v.pc4 = 32'd4; v.exp_alu = 32'd12; tbl.push_back(v);
        v = blank(); v.br = 1'b1; v.f3 = 3'b100; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 32'd1;
        v.pc = 32'h100; v.imm = 32'hFFFF_FFF8; v.exp_alu = 32'd0; v.exp_pcsrc = 1'b1;
        v.exp_tgt = 32'hF8; tbl.push_back(v);
        v.f3 = 3'b110; v.exp_pcsrc = 1'b0; tbl.push_back(v);
        v = blank(); v.jmp = 1'b1; v.jalr = 1'b1; v.rd1 = 32'h1001; v.imm = 32'd4;
        v.asel = 1'b1; v.bsel = 2'b10; v.pc = 32'h200; v.rw = 1'b1; v.rdx = 5'd1;
        v.exp_alu = 32'h204; v.exp_pcsrc = 1'b1; v.exp_tgt = 32'h1004; tbl.push_back(v);
        v = blank(); v.op = 4'd9; v.rd1 = 32'h8000_0000; v.rd2 = 32'd31;
        v.exp_alu = 32'hFFFF_FFFF; tbl.push_back(v);
        v.op = 4'd8; v.exp_alu = 32'd1; tbl.push_back(v);
        v = blank(); v.op = 4'd5; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 32'd1; v.exp_alu = 32'd1;
        tbl.push_back(v);
        v.op = 4'd6; v.exp_alu = 32'd0; tbl.push_back(v);
        v = blank(); v.op = 4'd15; v.rd1 = 32'd123; v.rd2 = 32'd456; v.exp_alu = 32'd0;
        tbl.push_back(v);
        v = blank(); v.op = 4'd10; v.bsel = 2'b01; v.imm = 32'h1234_5000;
        v.exp_alu = 32'h1234_5000; v.exp_tgt = 32'h1234_5000; tbl.push_back(v);
        v = blank(); v.op = 4'd1; v.rd1 = 32'd3; v.rd2 = 32'd5; v.exp_alu = 32'hFFFF_FFFE;
        tbl.push_back(v);
        v = blank(); v.op = 4'd0; v.bsel = 2'b11; v.rd1 = 32'd9; v.rd2 = 32'd100;
        v.exp_alu = 32'd9; tbl.push_back(v);
        v = blank(); v.op = 4'd7; v.rd1 = 32'h0000_0003; v.rd2 = 32'd4; v.exp_alu = 32'h30;
        v.br = 1'b1; v.f3 = 3'b010; tbl.push_back(v);

        // Reset held with random inputs: all EX/MEM outputs stay zero across edges.
        reset = 1'b0;
        drive(rand_vec());
        repeat (3) begin
            @(posedge clk);
            #1;
            drive(rand_vec());
        end
        chk_all_zero("reset_hold");
        exp_m = 32'd0;
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Forwarding: M-stage result into A, then W-stage result into B as store data.
        v = blank(); v.rd1 = 32'd8; v.rd2 = 32'd8; v.rw = 1'b1; v.exp_alu = 32'h10;
        run_vec("fwd_seed", v);
        v = blank(); v.op = 4'd1; v.fa = 2'b10; v.rd1 = 32'hDEAD; v.rd2 = 32'd1;
        v.exp_alu = 32'h0F; run_vec("fwd_m", v);
        v = blank(); v.fb = 2'b01; v.resw = 32'd3; v.mw = 1'b1; v.rd2 = 32'hAAAA;
        v.exp_alu = 32'd3; run_vec("fwd_w", v);
        chk("fwd_w.store_data", WriteDataM, 32'd3);
        v = blank(); v.fa = 2'b11; v.fb = 2'b11; v.rd1 = 32'd20; v.rd2 = 32'd22;
        v.resw = 32'd99; v.br = 1'b1; v.f3 = 3'b001; v.exp_alu = 32'd42; v.exp_pcsrc = 1'b1;
        run_vec("fwd_11", v);

        // Bubble after a live instruction: control clears, data still computed.
        v = blank(); v.rw = 1'b1; v.mw = 1'b1; v.rdx = 5'd7; v.rd1 = 32'd1; v.exp_alu = 32'd1;
        run_vec("live", v);
        v = blank(); v.rd1 = 32'd1; v.rd2 = 32'd2; v.exp_alu = 32'd3; run_vec("bubble", v);

        // Asynchronous reset between edges.
        v = blank(); v.rw = 1'b1; v.rsrc = 2'b10; v.f3 = 3'd2; v.rdx = 5'd9; v.pc4 = 32'h44;
        v.rd1 = 32'h55; v.rd2 = 32'h66; v.exp_alu = 32'hBB; run_vec("pre_async", v);
        #2;
        reset = 1'b0;
        v = blank(); v.jmp = 1'b1; v.pc = 32'h80; v.imm = 32'h10; drive(v);
        #1;
        chk_all_zero("async_reset");
        chk("async_reset.PCSrcE", 32'(PCSrcE), 32'd1);
        chk("async_reset.PCTargetE", PCTargetE, 32'h90);
        exp_m = 32'd0;
        @(negedge clk);
        reset = 1'b1;

        // Random stimulus against the reference model.
        for (int n = 0; n < 300; n++) begin
            v = model(rand_vec(), exp_m);
            run_vec($sformatf("rand%0d", n), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Consumes the control and data outputs of the ID/EX pipeline register.
- Performs operand forwarding, source muxing, the ALU operation and branch/jump resolution.
- Registers the results into the EX/MEM pipeline register that feeds the memory stage. PCSrcE/PCTargetE go combinationally back to fetch.

Parameters:
XLEN, 32, datapath width
REGW, 5, register-index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
RegWriteE  in  1  register write enable from ID/EX
MemWriteE  in  1  store enable from ID/EX
JumpE  in  1  unconditional jump (jal/jalr)
JalrE  in  1  jump target is register-relative
BranchE  in  1  conditional branch
ALUSrcAE  in  1  0=forwarded rs1, 1=PCE
ALUSrcBE  in  2  00=forwarded rs2, 01=ImmExtE, 10=constant 4, 11=zero
ResultSrcE  in  2  writeback select, passed through
ALUControlE  in  4  ALU operation
funct3E  in  3  branch condition / load-store size
RD1E, RD2E  in  XLEN  register-file read data
PCE, PCPlus4E, ImmExtE  in  XLEN  PC, PC+4, sign-extended immediate
RdE  in  REGW  destination register
ForwardAE, ForwardBE  in  2  00=RDxE, 01=ResultW, 10=ALUResultM, 11=RDxE
ResultW  in  XLEN  writeback-stage result
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  XLEN  redirect target (combinational)
RegWriteM, MemWriteM  out  1  registered control
ResultSrcM  out  2  registered
funct3M  out  3  registered
ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered
RdM  out  REGW  registered

Behaviour:
- Forwarding:
  - FwdA = mux(ForwardAE; RD1E, ResultW, ALUResultM). FwdB is the same using RD2E.
  - Encoding 11 selects RDxE.
  - ALUResultM is this block's own registered output, fed back.
- SrcA = ALUSrcAE ? PCE : FwdA. SrcB is selected per ALUSrcBE.
- ALUControlE encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt (signed, result 1/0), 0110 sltu
  - 0111 sll, 1000 srl, 1001 sra; shift amount = SrcB[4:0]
  - 1010 pass SrcB (lui)
  - 1011–1111 produce 0
- Add/sub wrap modulo 2^XLEN; no overflow flag.
- Branch compare uses FwdA vs FwdB, independent of ALUControlE:
  - funct3 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - 010/011 never taken.
- PCSrcE = JumpE | (BranchE & cond).
- PCTargetE:
  - JalrE=1: (FwdA + ImmExtE) with bit0 forced to 0.
  - JalrE=0: PCE + ImmExtE.
- EX/MEM register, updated on each rising clk edge:
  - RegWriteM←RegWriteE, MemWriteM←MemWriteE, ResultSrcM←ResultSrcE, funct3M←funct3E
  - ALUResultM←ALU result, WriteDataM←FwdB (post-forwarding store data)
  - PCPlus4M←PCPlus4E, RdM←RdE
- Latency: 1 cycle from E inputs to M outputs. PCSrcE/PCTargetE have 0-cycle latency.
- Reset (reset=0, asynchronous): all registered outputs go to 0 immediately, and stay 0 while reset is held.
- First capture happens on the first rising edge after reset deasserts.
- The stage has no stall or flush inputs. Bubbles arrive from ID/EX as all-zero control, and propagate as RegWriteM=0, MemWriteM=0.
- Reset asserted mid-operation discards the in-flight instruction. PCSrcE still follows its combinational inputs.
- Forward-from-M uses the value currently held in ALUResultM, i.e. the previous instruction's result.

Test Plan:
1. Reset: hold reset=0 with random inputs → every M output is 0. Release, apply add RD1E=5, RD2E=7, ALUControlE=0000 → next edge ALUResultM=12, RegWriteM follows RegWriteE.
2. Forwarding: cycle 1 add giving 0x10. Cycle 2 ForwardAE=10, RD1E=0xDEAD, RD2E=1, sub → ALUResultM=0x0F. Repeat with ForwardBE=01, ResultW=3, MemWriteE=1 → WriteDataM=3.
3. Branches: BranchE=1, funct3=100, FwdA=0xFFFFFFFF, FwdB=1 → PCSrcE=1. funct3=110 with the same operands → PCSrcE=0. PCE=0x100, ImmExtE=0xFFFFFFF8 → PCTargetE=0xF8.
4. jalr: JumpE=JalrE=1, FwdA=0x1001, ImmExtE=4 → PCTargetE=0x1004, PCSrcE=1. With ALUSrcAE=1, ALUSrcBE=10, PCE=0x200 → ALUResultM=0x204.
5. ALU corners:
   - sra 0x80000000 by 31 → 0xFFFFFFFF; srl by 31 → 1.
   - add 0xFFFFFFFF+1 → 0.
   - slt(-1,1)=1, sltu(-1,1)=0.
   - ALUControlE=1111 → 0.
6. Bubble/async reset: zero-control bubble → RegWriteM=MemWriteM=0. Drop reset mid-cycle between edges → outputs clear without waiting for clk.
